aes_byte_loader: RTL and testbench
==================================

Name: aes_byte_loader

Overview:
- Byte-wide register front end sitting directly upstream of aes_core.
- Host writes key, plaintext and control bytes over an 8-bit addressed bus. The block assembles the 256-bit key and 128-bit data words, pulses the core's load input and tracks the core's busy flag.
- It captures the 128-bit result and exposes result and status for byte-serial readback.

Parameters:
- TIMEOUT_CYCLES, 4096: cycles allowed from load pulse to result; used only when AES_LOADER_TIMEOUT_EN is defined.
- CNT_W, 13: timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en_i  in  1  host write strobe, one byte per cycle.
- rd_en_i  in  1  host read strobe.
- addr_i  in  6  host byte address.
- wdata_i  in  8  host write data.
- rdata_o  out  8  read data, valid one cycle after rd_en_i.
- busy_o  out  1  operation in progress.
- done_o  out  1  sticky; result available.
- core_load_o  out  1  one-cycle load pulse to core.
- core_key_o  out  256  assembled key.
- core_data_o  out  128  assembled plaintext.
- core_size_o  out  2  key size code from control register.
- core_dec_o  out  1  decrypt select from control register.
- core_data_i  in  128  core result.
- core_busy_i  in  1  core busy flag.

Behaviour:
- Address map:
  - 0x00-0x1F: key bytes. Byte n maps to key[255-8n -: 8].
  - 0x20-0x2F: writes go to plaintext byte n-0x20 (MSB first). Reads return result byte n-0x20.
  - 0x30: control. bit0 = go (self-clearing), bit1 = dec, bits3:2 = size.
  - 0x31: status, read-only. bit0 = busy, bit1 = done, bit2 = err, bit3 = timeout. Writing 0x31 clears err and timeout.
  - Unmapped reads return 0x00. Unmapped writes are ignored.
- Reset values: all outputs 0, key/plaintext/result registers 0, state IDLE.
- FSM states: IDLE, LOAD, WAIT_START, RUN.
  - IDLE: a write to 0x30 with bit0=1 latches dec/size, clears done_o, and moves to LOAD.
  - LOAD: core_load_o=1 for exactly one cycle; then WAIT_START.
  - WAIT_START: waits for core_busy_i=1, then RUN.
  - RUN: when core_busy_i=0 is sampled, latch core_data_i into the result register, set done_o, return to IDLE.
  - busy_o = 1 in every state except IDLE.
- Latency: load pulse the cycle after the go write. Result visible to host one cycle after core_busy_i is sampled low.
- Writes while busy_o=1 to key, plaintext or control are dropped and set err. Writes to 0x31 are always accepted.
- A go write with bit0=0 updates dec/size only.
- Simultaneous wr_en_i and rd_en_i: both honoured; the read returns the pre-write value.
- core_key_o and core_data_o are driven directly from the registers and stay stable throughout an operation.
- Reset mid-operation: returns to IDLE next edge, drops core_load_o, clears all status bits.

Optional Feature:
- AES_LOADER_TIMEOUT_EN defined:
  - Counter runs in LOAD/WAIT_START/RUN.
  - On reaching TIMEOUT_CYCLES, go to IDLE, set timeout bit, leave done_o=0 and result unchanged.
- Macro undefined:
  - No counter logic; waits indefinitely.
  - Status bit3 reads 0.

Decomposition:
- Package aes_loader_pkg holds: address constants (KEY_BASE, PT_BASE, CTRL_ADDR, STAT_ADDR), FSM state enum, status bit indices.
- Natural sub-module: aes_loader_regs, holding key/plaintext/result byte storage, write decode and the readback mux.
- The FSM stays in aes_byte_loader.

Test Plan:
- Write key bytes 00..0F (rest 0), plaintext 00112233445566778899AABBCCDDEEFF, size 0, go; model core returns 69C4E0D86A7B0430D8CDB78070B4C55A after 12 cycles -> one load pulse, done_o=1, reads 0x20..0x2F return 69,C4,...,5A.
- Write 0x20 = 0xAA while busy -> core_data_o unchanged, status reads 0x05; then write 0x31 -> status reads 0x01.
- Assert rst 3 cycles into RUN -> next cycle busy_o=0, core_load_o=0, status reads 0x00, later core_busy_i fall ignored.
- With AES_LOADER_TIMEOUT_EN and TIMEOUT_CYCLES=16, core never asserts busy -> at cycle 16 busy_o=0, status reads 0x08, result still 0.
- Back-to-back ops: second go written the cycle after done_o rises -> done_o clears, second result captured, exactly two load pulses total.
- Read 0x3F -> 0x00; read latency exactly one cycle for all addresses.

Source files
------------

// File: rtl/aes_loader_pkg.sv
// Shared definitions for the AES byte loader front end.
//   - host address map constants (key, plaintext/result, control, status)
//   - operation FSM state encoding
//   - bit positions inside the control and status bytes
package aes_loader_pkg;

    localparam logic [5:0] KEY_BASE  = 6'h00;  // 0x00-0x1F key bytes
    localparam logic [5:0] PT_BASE   = 6'h20;  // 0x20-0x2F plaintext (wr) / result (rd)
    localparam logic [5:0] CTRL_ADDR = 6'h30;
    localparam logic [5:0] STAT_ADDR = 6'h31;

    localparam int KEY_BYTES = 32;
    localparam int PT_BYTES  = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_START,
        ST_RUN
    } state_t;

    // Control byte fields
    localparam int CTRL_GO      = 0;
    localparam int CTRL_DEC     = 1;
    localparam int CTRL_SIZE_LO = 2;  // size occupies bits 3:2

    // Status byte fields
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_ERR     = 2;
    localparam int STAT_TIMEOUT = 3;

endpackage

// File: rtl/aes_loader_regs.sv
// Byte storage and host access path for the AES byte loader.
//   clk, rst        : clock, synchronous active-high reset
//   wr_en, addr,
//   wdata           : host byte write
//   wr_allow        : key/plaintext writes accepted only when high (no operation running)
//   rd_en           : host read strobe; rdata is registered, valid the cycle after
//   result_we,
//   result          : capture strobe and 128-bit core result
//   ctrl_byte,
//   stat_byte       : current control/status bytes supplied by the FSM for readback
//   key, pt         : assembled 256-bit key and 128-bit plaintext, byte 0 in the MSBs
//   rdata           : read data
module aes_loader_regs
    import aes_loader_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic         wr_allow,
    input  logic [5:0]   addr,
    input  logic [7:0]   wdata,
    input  logic         rd_en,
    input  logic         result_we,
    input  logic [127:0] result,
    input  logic [7:0]   ctrl_byte,
    input  logic [7:0]   stat_byte,
    output logic [255:0] key,
    output logic [127:0] pt,
    output logic [7:0]   rdata
);

    logic [7:0] key_mem [KEY_BYTES];
    logic [7:0] pt_mem  [PT_BYTES];
    logic [7:0] res_mem [PT_BYTES];

    logic       key_hit;
    logic       pt_hit;
    logic [7:0] rdata_reg;
    logic [7:0] rdata_next;

    assign key_hit = (addr[5] == KEY_BASE[5]);
    assign pt_hit  = (addr[5:4] == PT_BASE[5:4]);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < KEY_BYTES; i++) key_mem[i] <= '0;
            for (int i = 0; i < PT_BYTES; i++) begin
                pt_mem[i]  <= '0;
                res_mem[i] <= '0;
            end
        end else begin
            if (wr_en && wr_allow && key_hit) key_mem[addr[4:0]] <= wdata;
            if (wr_en && wr_allow && pt_hit)  pt_mem[addr[3:0]]  <= wdata;
            if (result_we) begin
                for (int i = 0; i < PT_BYTES; i++) res_mem[i] <= result[127-8*i -: 8];
            end
        end
    end

    // Byte n of each array sits in the MSB end of the assembled word.
    genvar gi;
    for (gi = 0; gi < KEY_BYTES; gi++) begin : g_key
        assign key[255-8*gi -: 8] = key_mem[gi];
    end
    for (gi = 0; gi < PT_BYTES; gi++) begin : g_pt
        assign pt[127-8*gi -: 8] = pt_mem[gi];
    end

    // The key is write-only so it cannot be read back over the host bus.
    // Reads sample the registers before any same-cycle write lands.
    always_comb begin
        rdata_next = 8'h00;
        if (pt_hit) begin
            rdata_next = res_mem[addr[3:0]];
        end else if (addr == CTRL_ADDR) begin
            rdata_next = ctrl_byte;
        end else if (addr == STAT_ADDR) begin
            rdata_next = stat_byte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_reg <= '0;
        end else if (rd_en) begin
            rdata_reg <= rdata_next;
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/aes_byte_loader.sv
// Byte-wide host register front end for aes_core.
// Assembles key/plaintext from host byte writes, issues a one-cycle load
// pulse on a go write, follows the core busy flag and captures the result.
//   clk, rst       : clock, synchronous active-high reset
//   wr_en_i, rd_en_i, addr_i, wdata_i, rdata_o : host byte bus (rdata_o one cycle after rd_en_i)
//   busy_o, done_o : operation in progress / sticky result available
//   core_load_o, core_key_o, core_data_o, core_size_o, core_dec_o : to aes_core
//   core_data_i, core_busy_i : from aes_core
// Optional feature macro: AES_LOADER_TIMEOUT_EN adds a load-to-result timeout
// of TIMEOUT_CYCLES cycles (counter width CNT_W) reported in status bit 3.
module aes_byte_loader
    import aes_loader_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 13
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic         rd_en_i,
    input  logic [5:0]   addr_i,
    input  logic [7:0]   wdata_i,
    output logic [7:0]   rdata_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         core_load_o,
    output logic [255:0] core_key_o,
    output logic [127:0] core_data_o,
    output logic [1:0]   core_size_o,
    output logic         core_dec_o,
    input  logic [127:0] core_data_i,
    input  logic         core_busy_i
);

    if ((64'd1 << CNT_W) <= 64'(TIMEOUT_CYCLES)) begin : g_cnt_w_check
        $error("CNT_W too narrow for TIMEOUT_CYCLES");
    end

    state_t      state_reg, state_next;
    logic        dec_reg,  dec_next;
    logic [1:0]  size_reg, size_next;
    logic        done_reg, done_next;
    logic        err_reg,  err_next;
    logic        result_we;
    logic        busy;
    logic        ctrl_wr;
    logic        stat_wr;
    logic        host_region_wr;
    logic        tout_bit;
    logic [7:0]  ctrl_byte;
    logic [7:0]  stat_byte;

    assign busy           = (state_reg != ST_IDLE);
    assign ctrl_wr        = wr_en_i && (addr_i == CTRL_ADDR);
    assign stat_wr        = wr_en_i && (addr_i == STAT_ADDR);
    // Key, plaintext and control all live at or below the control address.
    assign host_region_wr = wr_en_i && (addr_i <= CTRL_ADDR);

`ifdef AES_LOADER_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic             tout_reg, tout_next;
    logic             timeout_hit;

    // Counter is 0 in the LOAD cycle, so the operation is abandoned after
    // exactly TIMEOUT_CYCLES busy cycles.
    assign timeout_hit = busy && (cnt_reg == TIMEOUT_LAST);
    assign tout_bit    = tout_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_reg  <= '0;
            tout_reg <= 1'b0;
        end else begin
            tout_reg <= tout_next;
            cnt_reg  <= busy ? cnt_reg + 1'b1 : '0;
        end
    end
`else
    assign tout_bit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        dec_next   = dec_reg;
        size_next  = size_reg;
        done_next  = done_reg;
        err_next   = err_reg;
        result_we  = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
        tout_next  = tout_reg;
`endif
        case (state_reg)
            ST_IDLE: begin
                if (ctrl_wr) begin
                    dec_next  = wdata_i[CTRL_DEC];
                    size_next = wdata_i[CTRL_SIZE_LO +: 2];
                    if (wdata_i[CTRL_GO]) begin
                        done_next  = 1'b0;
                        state_next = ST_LOAD;
                    end
                end
            end
            ST_LOAD: begin
                state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (core_busy_i) state_next = ST_RUN;
            end
            ST_RUN: begin
                if (!core_busy_i) begin
                    result_we  = 1'b1;
                    done_next  = 1'b1;
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Register writes during an operation are dropped (storage gates them
        // on !busy) and flagged.
        if (busy && host_region_wr) err_next = 1'b1;

        if (stat_wr) begin
            err_next = 1'b0;
`ifdef AES_LOADER_TIMEOUT_EN
            tout_next = 1'b0;
`endif
        end

`ifdef AES_LOADER_TIMEOUT_EN
        // A result arriving on the last allowed cycle still counts as done.
        if (timeout_hit && !result_we) begin
            state_next = ST_IDLE;
            tout_next  = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            dec_reg   <= 1'b0;
            size_reg  <= 2'b00;
            done_reg  <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            dec_reg   <= dec_next;
            size_reg  <= size_next;
            done_reg  <= done_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        stat_byte               = 8'h00;
        stat_byte[STAT_BUSY]    = busy;
        stat_byte[STAT_DONE]    = done_reg;
        stat_byte[STAT_ERR]     = err_reg;
        stat_byte[STAT_TIMEOUT] = tout_bit;
    end

    assign ctrl_byte = {4'b0000, size_reg, dec_reg, 1'b0};

    aes_loader_regs u_regs (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en_i),
        .wr_allow  (!busy),
        .addr      (addr_i),
        .wdata     (wdata_i),
        .rd_en     (rd_en_i),
        .result_we (result_we),
        .result    (core_data_i),
        .ctrl_byte (ctrl_byte),
        .stat_byte (stat_byte),
        .key       (core_key_o),
        .pt        (core_data_o),
        .rdata     (rdata_o)
    );

    assign busy_o      = busy;
    assign done_o      = done_reg;
    assign core_load_o = (state_reg == ST_LOAD);
    assign core_size_o = size_reg;
    assign core_dec_o  = dec_reg;

endmodule

// File: tb/tb_aes_byte_loader.sv
module tb_aes_byte_loader;

    localparam int TB_TIMEOUT = 16;

    localparam logic [255:0] KEY_EXP = {128'h000102030405060708090A0B0C0D0E0F, 128'h0};
    localparam logic [127:0] PT_EXP  = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [127:0] RES1    = 128'h69C4E0D86A7B0430D8CDB78070B4C55A;
    localparam logic [127:0] RES2    = 128'h0123456789ABCDEFFEDCBA9876543210;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         wr_en_i = 1'b0;
    logic         rd_en_i = 1'b0;
    logic [5:0]   addr_i = '0;
    logic [7:0]   wdata_i = '0;
    logic [7:0]   rdata_o;
    logic         busy_o;
    logic         done_o;
    logic         core_load_o;
    logic [255:0] core_key_o;
    logic [127:0] core_data_o;
    logic [1:0]   core_size_o;
    logic         core_dec_o;
    logic [127:0] core_data_i = '0;
    logic         core_busy_i = 1'b0;

    int tests = 0;
    int fails = 0;

    // Behavioural core: busy rises the edge after a load pulse, falls core_lat
    // cycles later together with the result. It ignores rst on purpose.
    int           core_lat = 12;
    logic [127:0] core_res = '0;
    bit           core_en = 1'b1;
    int           busy_cnt = 0;
    int           load_count = 0;

    always #5 clk = ~clk;

    aes_byte_loader #(.TIMEOUT_CYCLES(TB_TIMEOUT), .CNT_W(13)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en_i),
        .rd_en_i     (rd_en_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .core_load_o (core_load_o),
        .core_key_o  (core_key_o),
        .core_data_o (core_data_o),
        .core_size_o (core_size_o),
        .core_dec_o  (core_dec_o),
        .core_data_i (core_data_i),
        .core_busy_i (core_busy_i)
    );

    always @(posedge clk) begin
        if (core_load_o) load_count <= load_count + 1;
        if (core_en && core_load_o) begin
            core_busy_i <= 1'b1;
            busy_cnt    <= core_lat;
        end else if (busy_cnt > 1) begin
            busy_cnt <= busy_cnt - 1;
        end else if (busy_cnt == 1) begin
            busy_cnt    <= 0;
            core_busy_i <= 1'b0;
            core_data_i <= core_res;
        end
    end

    task automatic wr(input logic [5:0] a, input logic [7:0] d);
        wr_en_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk); #1;
        wr_en_i = 1'b0;
        $display("[TB] wr addr=%02h data=%02h", a, d);
    endtask

    task automatic rd(input logic [5:0] a, output logic [7:0] d);
        rd_en_i = 1'b1; addr_i = a;
        @(posedge clk); #1;
        rd_en_i = 1'b0;
        d = rdata_o;
        $display("[TB] rd addr=%02h data=%02h", a, d);
    endtask

    task automatic test_reset();
        logic [7:0] d;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || core_load_o !== 1'b0 || rdata_o !== 8'h00) begin
            fails++;
            $display("FAIL reset_outputs busy=%b done=%b load=%b rdata=%02h required all 0", busy_o, done_o, core_load_o, rdata_o);
        end
        tests++;
        if (core_key_o !== 256'h0 || core_data_o !== 128'h0 || core_size_o !== 2'b00 || core_dec_o !== 1'b0) begin
            fails++;
            $display("FAIL reset_regs key=%h data=%h size=%0d dec=%b required 0", core_key_o, core_data_o, core_size_o, core_dec_o);
        end
        rst = 1'b0;
        rd(6'h31, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL reset_status got=%02h exp=00", d);
        end
    endtask

    task automatic test_basic_op();
        logic [7:0]   d;
        logic [127:0] r;
        int           start;
        int           n;
        for (int i = 0; i < 32; i++) wr(6'(i), (i < 16) ? 8'(i) : 8'h00);
        r = PT_EXP;
        for (int i = 0; i < 16; i++) wr(6'(8'h20 + i), r[127-8*i -: 8]);
        tests++;
        if (core_key_o !== KEY_EXP || core_data_o !== PT_EXP) begin
            fails++;
            $display("FAIL assembly key=%h data=%h", core_key_o, core_data_o);
        end
        core_lat = 12; core_res = RES1;
        start = load_count;
        wr(6'h30, 8'h01);
        tests++;
        if (core_load_o !== 1'b1 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL load_latency load=%b busy=%b exp 1 1", core_load_o, busy_o);
        end
        @(posedge clk); #1;
        tests++;
        if (core_load_o !== 1'b0) begin
            fails++;
            $display("FAIL load_width load=%b exp 0", core_load_o);
        end
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        tests++;
        if (done_o !== 1'b1) begin
            fails++;
            $display("FAIL basic_done done=%b exp 1 after %0d cycles", done_o, n);
        end
        tests++;
        if (load_count - start !== 1 || busy_o !== 1'b0 || core_size_o !== 2'd0 || core_dec_o !== 1'b0) begin
            fails++;
            $display("FAIL basic_state loads=%0d busy=%b size=%0d dec=%b exp 1 0 0 0", load_count - start, busy_o, core_size_o, core_dec_o);
        end
        r = RES1;
        for (int i = 0; i < 16; i++) begin
            rd(6'(8'h20 + i), d);
            tests++;
            if (d !== r[127-8*i -: 8]) begin
                fails++;
                $display("FAIL result_byte%0d got=%02h exp=%02h", i, d, r[127-8*i -: 8]);
            end
        end
        rd(6'h31, d);
        tests++;
        if (d !== 8'h02) begin
            fails++;
            $display("FAIL basic_status got=%02h exp=02", d);
        end
    endtask

    task automatic test_busy_write();
        logic [7:0] d;
        int         n;
        core_lat = 12; core_res = RES1;
        wr(6'h30, 8'h0B);  // go, dec=1, size=2
        repeat (3) @(posedge clk);
        #1;
        wr(6'h20, 8'hAA);
        tests++;
        if (core_data_o !== PT_EXP || core_key_o !== KEY_EXP) begin
            fails++;
            $display("FAIL busy_drop data=%h exp=%h", core_data_o, PT_EXP);
        end
        // simultaneous read and clear of status: read sees pre-write value
        wr_en_i = 1'b1; rd_en_i = 1'b1; addr_i = 6'h31; wdata_i = 8'hFF;
        @(posedge clk); #1;
        wr_en_i = 1'b0; rd_en_i = 1'b0;
        d = rdata_o;
        $display("[TB] rdwr addr=31 data=%02h", d);
        tests++;
        if (d !== 8'h05) begin
            fails++;
            $display("FAIL busy_err_status got=%02h exp=05", d);
        end
        rd(6'h31, d);
        tests++;
        if (d !== 8'h01) begin
            fails++;
            $display("FAIL err_clear got=%02h exp=01", d);
        end
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        tests++;
        if (done_o !== 1'b1 || core_dec_o !== 1'b1 || core_size_o !== 2'd2) begin
            fails++;
            $display("FAIL busy_done done=%b dec=%b size=%0d exp 1 1 2", done_o, core_dec_o, core_size_o);
        end
        rd(6'h31, d);
        tests++;
        if (d !== 8'h02) begin
            fails++;
            $display("FAIL busy_final_status got=%02h exp=02", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        int         start;
        int         n;
        core_lat = 5; core_res = RES1;
        start = load_count;
        wr(6'h30, 8'h01);
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        tests++;
        if (done_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_first_done done=%b exp 1", done_o);
        end
        core_res = RES2;
        wr(6'h30, 8'h01);
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b1) begin
            fails++;
            $display("FAIL b2b_done_clear done=%b busy=%b exp 0 1", done_o, busy_o);
        end
        n = 0;
        while (done_o !== 1'b1 && n < 100) begin @(posedge clk); #1; n++; end
        tests++;
        if (done_o !== 1'b1 || load_count - start !== 2) begin
            fails++;
            $display("FAIL b2b_second done=%b loads=%0d exp 1 2", done_o, load_count - start);
        end
        rd(6'h20, d);
        tests++;
        if (d !== 8'h01) begin
            fails++;
            $display("FAIL b2b_res_first got=%02h exp=01", d);
        end
        rd(6'h2F, d);
        tests++;
        if (d !== 8'h10) begin
            fails++;
            $display("FAIL b2b_res_last got=%02h exp=10", d);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] d;
        wr(6'h3F, 8'hFF);
        rd(6'h3F, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL unmapped_3f got=%02h exp=00", d);
        end
        rd(6'h32, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL unmapped_32 got=%02h exp=00", d);
        end
        rd_en_i = 1'b1; addr_i = 6'h20;
        #2;
        tests++;
        if (rdata_o !== 8'h00) begin
            fails++;
            $display("FAIL read_latency_early got=%02h exp=00", rdata_o);
        end
        @(posedge clk); #1;
        rd_en_i = 1'b0;
        $display("[TB] rd addr=20 data=%02h", rdata_o);
        tests++;
        if (rdata_o !== 8'h01) begin
            fails++;
            $display("FAIL read_latency_one got=%02h exp=01", rdata_o);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] d;
        int         start;
        core_lat = 20; core_res = RES1;
        start = load_count;
        wr(6'h30, 8'h01);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (busy_o !== 1'b0 || core_load_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset busy=%b load=%b done=%b exp 0 0 0", busy_o, core_load_o, done_o);
        end
        rst = 1'b0;
        rd(6'h31, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_status got=%02h exp=00", d);
        end
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if (done_o !== 1'b0 || busy_o !== 1'b0 || load_count - start !== 1) begin
            fails++;
            $display("FAIL mid_reset_ignore done=%b busy=%b loads=%0d exp 0 0 1", done_o, busy_o, load_count - start);
        end
        rd(6'h20, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL mid_reset_result got=%02h exp=00", d);
        end
    endtask

`ifdef AES_LOADER_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] d;
        core_en = 1'b0;
        wr(6'h30, 8'h01);
        repeat (TB_TIMEOUT - 1) @(posedge clk);
        #1;
        tests++;
        if (busy_o !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early busy=%b exp 1", busy_o);
        end
        @(posedge clk); #1;
        tests++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            fails++;
            $display("FAIL timeout_expire busy=%b done=%b exp 0 0", busy_o, done_o);
        end
        rd(6'h31, d);
        tests++;
        if (d !== 8'h08) begin
            fails++;
            $display("FAIL timeout_status got=%02h exp=08", d);
        end
        rd(6'h20, d);
        tests++;
        if (d !== 8'h00) begin
            fails++;
            $display("FAIL timeout_result got=%02h exp=00", d);
        end
        core_en = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_op();
        test_busy_write();
        test_back_to_back();
        test_unmapped();
        test_reset_mid();
`ifdef AES_LOADER_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
